// File: rtl/opcode_pkg.sv
// Shared definitions for the opcode selector: legal opcode table and FSM state encoding.
package opcode_pkg;

    localparam int OP_COUNT = 10;
    localparam int IDX_W    = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        SELECT = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Opcode table: index 0..9 -> 0,1,2,3,4,5,6,7,9,14; unused indices map to 0.
    function automatic logic [31:0] op_lookup(input idx_t idx);
        logic [31:0] op;
        case (idx)
            4'd0:    op = 32'd0;
            4'd1:    op = 32'd1;
            4'd2:    op = 32'd2;
            4'd3:    op = 32'd3;
            4'd4:    op = 32'd4;
            4'd5:    op = 32'd5;
            4'd6:    op = 32'd6;
            4'd7:    op = 32'd7;
            4'd8:    op = 32'd9;
            4'd9:    op = 32'd14;
            default: op = 32'd0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> stability-counter debouncer -> one-cycle press pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
            // Any cycle of agreement restarts the stability count.
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
        end
    end

    assign press_o = r_press;

endmodule

// File: rtl/opcode_selector.sv
// Button-driven opcode selector: steps through the legal opcode table and locks a selection.
module opcode_selector
    import opcode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        next_i,
    input  logic        prev_i,
    input  logic        confirm_i,
    output logic [31:0] op_o,
    output logic        locked_o,
    output logic        op_strobe_o
);

    logic w_next;
    logic w_prev;
    logic w_confirm;
    idx_t w_idx_nxt;

    state_t      r_state;
    idx_t        r_idx;
    logic [31:0] r_op;
    logic        r_locked;
    logic        r_strobe;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (next_i),
        .press_o(w_next)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (prev_i),
        .press_o(w_prev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (confirm_i),
        .press_o(w_confirm)
    );

    // Simultaneous next and prev cancel out.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_next && !w_prev) begin
            w_idx_nxt = (r_idx == idx_t'(OP_COUNT - 1)) ? '0 : r_idx + 1'b1;
        end else if (w_prev && !w_next) begin
            w_idx_nxt = (r_idx == '0) ? idx_t'(OP_COUNT - 1) : r_idx - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= SELECT;
            r_idx    <= '0;
            r_op     <= '0;
            r_locked <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            unique case (r_state)
                SELECT: begin
                    if (w_confirm) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                        r_strobe <= 1'b1;
                    end else begin
                        r_idx <= w_idx_nxt;
                        r_op  <= op_lookup(w_idx_nxt);
                    end
                end
                LOCKED: begin
                    if (w_confirm) begin
                        r_state  <= SELECT;
                        r_locked <= 1'b0;
                    end
                end
                default: r_state <= SELECT;
            endcase
        end
    end

    assign op_o        = r_op;
    assign locked_o    = r_locked;
    assign op_strobe_o = r_strobe;

endmodule

// File: tb/tb_opcode_selector.sv
// Directed bench for opcode_selector with a short debounce window.
module tb_opcode_selector;

    localparam int DB = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        next_i;
    logic        prev_i;
    logic        confirm_i;
    logic [31:0] op_o;
    logic        locked_o;
    logic        op_strobe_o;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_strobe = 0;
    int s0;

    opcode_selector #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .next_i     (next_i),
        .prev_i     (prev_i),
        .confirm_i  (confirm_i),
        .op_o       (op_o),
        .locked_o   (locked_o),
        .op_strobe_o(op_strobe_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        #1;
        if (op_strobe_o) n_strobe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        next_i    = 1'b0;
        prev_i    = 1'b0;
        confirm_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic push(input logic n, input logic p, input logic c);
        @(negedge clk_i);
        next_i    = n;
        prev_i    = p;
        confirm_i = c;
        repeat (10) @(negedge clk_i);
        next_i    = 1'b0;
        prev_i    = 1'b0;
        confirm_i = 1'b0;
        repeat (12) @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq [10];
        seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd9, 32'd14, 32'd0};

        do_reset();
        chk("rst_op", op_o, 32'd0);
        chk("rst_locked", {31'd0, locked_o}, 32'd0);
        chk("rst_strobe", {31'd0, op_strobe_o}, 32'd0);

        // Latency: pulse on edge 7 after first sampled-high edge, op_o on edge 8.
        @(negedge clk_i);
        next_i = 1'b1;
        repeat (8) @(negedge clk_i);
        chk("lat_edge7", op_o, 32'd0);
        @(negedge clk_i);
        chk("lat_edge8", op_o, 32'd1);
        repeat (11) @(negedge clk_i);
        chk("held_op", op_o, 32'd1);
        next_i = 1'b0;
        repeat (12) @(negedge clk_i);
        chk("held_release", op_o, 32'd1);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(1'b1, 1'b0, 1'b0);
            chk($sformatf("seq_%0d", i), op_o, seq[i]);
        end

        do_reset();
        push(1'b0, 1'b1, 1'b0);
        chk("prev_wrap", op_o, 32'd14);
        @(negedge clk_i);
        next_i = 1'b1;
        repeat (2) @(negedge clk_i);
        next_i = 1'b0;
        repeat (12) @(negedge clk_i);
        chk("glitch", op_o, 32'd14);

        push(1'b0, 1'b1, 1'b0);
        chk("sel_9", op_o, 32'd9);
        s0 = n_strobe;
        @(negedge clk_i);
        confirm_i = 1'b1;
        repeat (8) @(negedge clk_i);
        chk("lock_edge7", {31'd0, locked_o}, 32'd0);
        @(negedge clk_i);
        chk("lock_edge8", {31'd0, locked_o}, 32'd1);
        chk("strobe_hi", {31'd0, op_strobe_o}, 32'd1);
        @(negedge clk_i);
        chk("strobe_lo", {31'd0, op_strobe_o}, 32'd0);
        repeat (8) @(negedge clk_i);
        confirm_i = 1'b0;
        repeat (12) @(negedge clk_i);
        chk("strobe_once", n_strobe - s0, 32'd1);
        push(1'b1, 1'b0, 1'b0);
        chk("locked_next_op", op_o, 32'd9);
        push(1'b0, 1'b1, 1'b0);
        chk("locked_prev_op", op_o, 32'd9);
        s0 = n_strobe;
        push(1'b0, 1'b0, 1'b1);
        chk("unlock", {31'd0, locked_o}, 32'd0);
        chk("unlock_nostrobe", n_strobe - s0, 32'd0);
        chk("unlock_op", op_o, 32'd9);

        do_reset();
        push(1'b1, 1'b0, 1'b0);
        chk("pre_cancel", op_o, 32'd1);
        push(1'b1, 1'b1, 1'b0);
        chk("cancel", op_o, 32'd1);
        s0 = n_strobe;
        push(1'b1, 1'b0, 1'b1);
        chk("prio_locked", {31'd0, locked_o}, 32'd1);
        chk("prio_op", op_o, 32'd1);
        chk("prio_strobe", n_strobe - s0, 32'd1);

        do_reset();
        push(1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b0);
        chk("sel_7", op_o, 32'd7);
        push(1'b0, 1'b0, 1'b1);
        chk("lock_7", {31'd0, locked_o}, 32'd1);
        s0 = n_strobe;
        @(negedge clk_i);
        confirm_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("arst_op", op_o, 32'd0);
        chk("arst_locked", {31'd0, locked_o}, 32'd0);
        chk("arst_strobe", {31'd0, op_strobe_o}, 32'd0);
        @(negedge clk_i);
        confirm_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("post_rst_strobe", n_strobe - s0, 32'd0);
        chk("post_rst_locked", {31'd0, locked_o}, 32'd0);
        chk("post_rst_op", op_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
